// File: rtl/ldpc_pkg.sv
// Shared LDPC front-end definitions.
//   LLR_OUT_W    : decoder soft-input width
//   CW_LEN_*     : supported codeword lengths (802.11n LDPC)
//   cw_beat_t    : one decoder input beat {sop, eop, llr}
//   sat_llr()    : symmetric clamp to +/-(2^(out_w-1)-1); the most negative code is never produced
package ldpc_pkg;

  localparam int unsigned LLR_OUT_W   = 6;
  localparam int unsigned CW_LEN_648  = 648;
  localparam int unsigned CW_LEN_1296 = 1296;
  localparam int unsigned CW_LEN_1944 = 1944;

  typedef struct packed {
    logic                        sop;
    logic                        eop;
    logic signed [LLR_OUT_W-1:0] llr;
  } cw_beat_t;

  function automatic logic signed [31:0] sat_llr(input logic signed [31:0] q,
                                                 input int unsigned       out_w);
    logic signed [31:0] lim;
    lim = (32'sd1 <<< (out_w - 1)) - 32'sd1;
    if (q > lim)
      return lim;
    else if (q < -lim)
      return -lim;
    else
      return q;
  endfunction

endpackage

// File: rtl/avalon_st_skid.sv
// Two-entry Avalon-ST skid buffer with a registered ready.
//   clk, rst      : clock, synchronous active-high reset
//   in_valid/in_ready/in_data    : upstream side; in_ready = skid entry empty
//   out_valid/out_ready/out_data : downstream side; held stable while stalled
module avalon_st_skid #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);

  logic              ov, sv, rdy;
  logic              ov_n, sv_n;
  logic [DATA_W-1:0] od, sd, od_n, sd_n;
  logic              push, pop;

  assign push      = in_valid & rdy;
  assign pop       = ov & out_ready;
  assign in_ready  = rdy;
  assign out_valid = ov;
  assign out_data  = od;

  // Pop is resolved first so a simultaneous push/pop with one entry held
  // passes straight through the output register. A push only happens while
  // the skid entry is empty, so the second entry can never be overwritten.
  always_comb begin
    ov_n = ov;
    sv_n = sv;
    od_n = od;
    sd_n = sd;
    if (pop) begin
      if (sv) begin
        od_n = sd;
        sv_n = 1'b0;
      end else begin
        ov_n = 1'b0;
      end
    end
    if (push) begin
      if (!ov_n) begin
        od_n = in_data;
        ov_n = 1'b1;
      end else begin
        sd_n = in_data;
        sv_n = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ov  <= 1'b0;
      sv  <= 1'b0;
      rdy <= 1'b0;
      od  <= '0;
      sd  <= '0;
    end else begin
      ov  <= ov_n;
      sv  <= sv_n;
      rdy <= ~sv_n;
      od  <= od_n;
      sd  <= sd_n;
    end
  end

endmodule

// File: rtl/llr_cw_framer.sv
// LDPC decoder input framer.
// Rounds, shifts and saturates signed demapper LLRs, then frames each codeword
// (started by in_sof) as one Avalon-ST packet of CW_LEN beats.
//   clk_clk, reset_reset            : clock, synchronous active-high reset
//   in_valid/in_ready/in_sof/in_data: LLR input stream
//   out_valid/out_ready/out_data    : decoder cw_in stream
//   out_startofpacket/out_endofpacket: packet delimiters
//   frame_cnt    : packets whose last beat was accepted (wraps)
//   sync_err_cnt : in_sof seen mid-frame (saturates at 255)
module llr_cw_framer
  import ldpc_pkg::*;
#(
  parameter int unsigned IN_W   = 16,
  parameter int unsigned OUT_W  = LLR_OUT_W,
  parameter int unsigned SHIFT  = 4,
  parameter int unsigned CW_LEN = CW_LEN_648
) (
  input  logic             clk_clk,
  input  logic             reset_reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sof,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_startofpacket,
  output logic             out_endofpacket,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [15:0]      frame_cnt,
  output logic [7:0]       sync_err_cnt
);

  localparam int unsigned IDX_W = (CW_LEN > 1) ? $clog2(CW_LEN) : 1;
  localparam int          RND_I = (SHIFT == 0) ? 0 : (1 << (SHIFT - 1));
  localparam logic signed [IN_W:0] RND = (IN_W + 1)'(RND_I);

  typedef enum logic {HUNT, FRAME} state_t;

  state_t           state, state_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic             accept, fwd, sop, eop, frame_inc, sync_err;
  logic signed [IN_W:0] t, q;
  logic signed [31:0]   q_sat;
  cw_beat_t         beat_in, beat_out;

  // Quantiser: one extra bit of headroom so the rounding offset cannot wrap.
  always_comb begin
    t     = $signed({in_data[IN_W-1], in_data}) + RND;
    q     = t >>> SHIFT;
    q_sat = sat_llr(32'(q), OUT_W);
  end

  assign accept = in_valid & in_ready;

  always_comb begin
    state_n   = state;
    idx_n     = idx;
    fwd       = 1'b0;
    sop       = 1'b0;
    eop       = 1'b0;
    frame_inc = 1'b0;
    sync_err  = 1'b0;
    if (accept) begin
      case (state)
        HUNT: begin
          if (in_sof) begin
            fwd     = 1'b1;
            sop     = 1'b1;
            idx_n   = IDX_W'(1);
            state_n = FRAME;
          end
        end
        FRAME: begin
          fwd      = 1'b1;
          sync_err = in_sof;
          if (idx == IDX_W'(CW_LEN - 1)) begin
            eop       = 1'b1;
            frame_inc = 1'b1;
            idx_n     = '0;
            state_n   = HUNT;
          end else begin
            idx_n = idx + IDX_W'(1);
          end
        end
        default: state_n = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state        <= HUNT;
      idx          <= '0;
      frame_cnt    <= '0;
      sync_err_cnt <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      if (frame_inc)
        frame_cnt <= frame_cnt + 16'd1;
      if (sync_err && sync_err_cnt != 8'hFF)
        sync_err_cnt <= sync_err_cnt + 8'd1;
    end
  end

  always_comb begin
    beat_in.sop = sop;
    beat_in.eop = eop;
    beat_in.llr = LLR_OUT_W'(q_sat);
  end

  // Discarded HUNT beats are consumed here and never pushed into the skid.
  avalon_st_skid #(
    .DATA_W($bits(cw_beat_t))
  ) u_skid (
    .clk       (clk_clk),
    .rst       (reset_reset),
    .in_valid  (fwd),
    .in_ready  (in_ready),
    .in_data   (beat_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (beat_out)
  );

  assign out_startofpacket = beat_out.sop;
  assign out_endofpacket   = beat_out.eop;
  assign out_data          = OUT_W'(beat_out.llr);

endmodule

// File: tb/tb_llr_cw_framer.sv
module tb_llr_cw_framer;

  localparam int CW = 648;
  localparam int SH = 4;

  logic        clk_clk = 1'b0;
  logic        reset_reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_sof = 1'b0;
  logic [15:0] in_data = '0;
  logic        out_startofpacket, out_endofpacket, out_valid;
  logic        out_ready = 1'b0;
  logic [5:0]  out_data;
  logic [15:0] frame_cnt;
  logic [7:0]  sync_err_cnt;

  always #5 clk_clk = ~clk_clk;

  llr_cw_framer #(
    .IN_W(16), .OUT_W(6), .SHIFT(SH), .CW_LEN(CW)
  ) dut (
    .clk_clk(clk_clk), .reset_reset(reset_reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof), .in_data(in_data),
    .out_startofpacket(out_startofpacket), .out_endofpacket(out_endofpacket),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .frame_cnt(frame_cnt), .sync_err_cnt(sync_err_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk_clk) cyc <= cyc + 1;

  // Reference model state: expected packet stream built from the framing rules.
  bit         m_in_frame = 0;
  int         m_pos = 0;
  int         m_frames = 0;
  int         m_sync = 0;
  int         n_pushed = 0;
  int         n_popped = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         got_cyc[$];
  int         sof_cyc = 0;
  int         last_acc_cyc = 0;
  int         mon_viol = 0;
  int         rdy_mode = 0;

  function automatic int quant(input int d);
    int t, q, step;
    step = 1 << SH;
    t = d + ((SH > 0) ? (step / 2) : 0);
    if (t >= 0) q = t / step;
    else        q = -((-t + step - 1) / step);
    if (q > 31)  q = 31;
    if (q < -31) q = -31;
    return q;
  endfunction

  function automatic int rnd_llr();
    logic signed [15:0] r;
    if ($urandom_range(0, 1) == 1) begin
      r = 16'($urandom);
      return int'(r);
    end
    return int'($urandom_range(0, 1200)) - 600;
  endfunction

  function automatic int queue_diff();
    int d;
    d = (exp_q.size() != got_q.size()) ? 1 : 0;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      if (exp_q[i] !== got_q[i]) d++;
    return d;
  endfunction

  // out_ready driver
  initial forever begin
    @(posedge clk_clk); #1;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  // Output monitor: captures accepted beats and checks handshake invariants
  // against the model's occupancy (pushed minus popped).
  bit         was_rst = 1;
  bit         prev_stall = 0;
  logic [7:0] prev_beat = '0;
  initial forever begin
    int occ;
    @(negedge clk_clk);
    if (reset_reset) begin
      was_rst = 1; prev_stall = 0;
      continue;
    end
    occ = n_pushed - n_popped;
    if (occ < 0 || occ > 2 || out_valid !== (occ > 0)) mon_viol++;
    if (!was_rst && in_ready === 1'b0 && occ != 2) mon_viol++;
    if (prev_stall && {out_startofpacket, out_endofpacket, out_data} !== prev_beat) mon_viol++;
    prev_stall = out_valid && !out_ready;
    prev_beat  = {out_startofpacket, out_endofpacket, out_data};
    if (out_valid && out_ready) begin
      got_q.push_back({out_startofpacket, out_endofpacket, out_data});
      got_cyc.push_back(cyc);
      n_popped++;
    end
    was_rst = 0;
  end

  task automatic send_beat(input bit sof, input int d);
    bit acc, ok;
    in_valid = 1'b1; in_sof = sof; in_data = 16'(d); ok = 0;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk_clk); acc = in_ready;
      @(posedge clk_clk); #1;
      if (acc) begin ok = 1; break; end
    end
    if (!ok) begin
      n_checks++; n_fail++;
      $display("FAIL send_beat_timeout: in_ready=%0b required=1", in_ready);
      return;
    end
    last_acc_cyc = cyc;
    if (!m_in_frame) begin
      if (sof) begin
        exp_q.push_back({1'b1, (CW == 1) ? 1'b1 : 1'b0, 6'(quant(d))});
        n_pushed++; sof_cyc = cyc; m_in_frame = 1; m_pos = 1;
      end
    end else begin
      exp_q.push_back({1'b0, (m_pos == CW - 1) ? 1'b1 : 1'b0, 6'(quant(d))});
      n_pushed++;
      if (sof && m_sync < 255) m_sync++;
      if (m_pos == CW - 1) begin m_in_frame = 0; m_pos = 0; m_frames++; end
      else m_pos++;
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0; in_sof = 1'b0;
    repeat (n) begin @(posedge clk_clk); #1; end
  endtask

  // Full codeword; in_sof is also raised on positions lo..hi (mid-frame).
  task automatic send_frame(input int lo, input int hi);
    send_beat(1'b1, rnd_llr());
    for (int p = 1; p < CW; p++) send_beat(p >= lo && p <= hi, rnd_llr());
  endtask

  task automatic drain_and_clear(input bit clear_after);
    int k;
    in_valid = 1'b0; in_sof = 1'b0;
    for (k = 0; k < 4000 && n_popped != n_pushed; k++) begin @(posedge clk_clk); #1; end
    if (n_popped != n_pushed) begin
      n_checks++; n_fail++;
      $display("FAIL drain_timeout: popped=%0d required=%0d", n_popped, n_pushed);
    end
    idle(2);
    if (clear_after) begin exp_q.delete(); got_q.delete(); got_cyc.delete(); end
  endtask

  task automatic test_reset();
    reset_reset = 1'b1; rdy_mode = 0;
    repeat (2) begin @(posedge clk_clk); #1; end
    n_checks++;
    if ({in_ready, out_valid, out_startofpacket, out_endofpacket, out_data, frame_cnt, sync_err_cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: rdy=%0b v=%0b sop=%0b eop=%0b d=%0h fc=%0d se=%0d required all 0",
               in_ready, out_valid, out_startofpacket, out_endofpacket, out_data, frame_cnt, sync_err_cnt);
    end
    reset_reset = 1'b0;
    @(posedge clk_clk); #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_reset: got=%0b required=1", in_ready); end
  endtask

  task automatic test_quant();
    logic [5:0] req[4];
    req[0] = 6'h02; req[1] = 6'h3F; req[2] = 6'h1F; req[3] = 6'h21;
    rdy_mode = 0;
    send_beat(1'b1, 24); send_beat(1'b0, -24); send_beat(1'b0, 32767); send_beat(1'b0, -32768);
    for (int p = 4; p < CW; p++) send_beat(1'b0, rnd_llr());
    drain_and_clear(0);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (got_q.size() <= i || got_q[i][5:0] !== req[i]) begin
        n_fail++;
        $display("FAIL quant_%0d: got=%0h required=%0h", i, (got_q.size() > i) ? got_q[i][5:0] : 6'hxx, req[i]);
      end
    end
    n_checks++;
    if (queue_diff() !== 0) begin n_fail++; $display("FAIL quant_stream: diffs=%0d required=0", queue_diff()); end
    n_checks++;
    if (frame_cnt !== 16'(m_frames)) begin n_fail++; $display("FAIL quant_frame_cnt: got=%0d required=%0d", frame_cnt, m_frames); end
    exp_q.delete(); got_q.delete(); got_cyc.delete();
  endtask

  task automatic test_framing();
    int fc0, nsop, neop;
    fc0 = int'(frame_cnt); rdy_mode = 0;
    for (int i = 0; i < 3; i++) send_beat(1'b0, rnd_llr());
    send_frame(1, 0);
    drain_and_clear(0);
    nsop = 0; neop = 0;
    foreach (got_q[i]) begin
      if (got_q[i][7]) nsop++;
      if (got_q[i][6]) neop++;
    end
    n_checks++;
    if (got_q.size() !== CW || nsop !== 1 || neop !== 1 || got_q[0][7] !== 1'b1 || got_q[CW-1][6] !== 1'b1) begin
      n_fail++;
      $display("FAIL framing_shape: beats=%0d sops=%0d eops=%0d required beats=%0d sops=1 eops=1 at 0/%0d",
               got_q.size(), nsop, neop, CW, CW - 1);
    end
    n_checks++;
    if (int'(frame_cnt) - fc0 !== 1) begin n_fail++; $display("FAIL framing_frame_cnt: delta=%0d required=1", int'(frame_cnt) - fc0); end
    n_checks++;
    if (queue_diff() !== 0) begin n_fail++; $display("FAIL framing_stream: diffs=%0d required=0", queue_diff()); end
    exp_q.delete(); got_q.delete(); got_cyc.delete();
  endtask

  task automatic test_backpressure();
    mon_viol = 0; rdy_mode = 1;
    send_frame(1, 0);
    send_frame(1, 0);
    drain_and_clear(0);
    rdy_mode = 0;
    n_checks++;
    if (got_q.size() !== 2 * CW || queue_diff() !== 0) begin
      n_fail++; $display("FAIL bp_stream: beats=%0d diffs=%0d required beats=%0d diffs=0", got_q.size(), queue_diff(), 2 * CW);
    end
    n_checks++;
    if (mon_viol !== 0) begin n_fail++; $display("FAIL bp_handshake: violations=%0d required=0", mon_viol); end
    n_checks++;
    if (frame_cnt !== 16'(m_frames)) begin n_fail++; $display("FAIL bp_frame_cnt: got=%0d required=%0d", frame_cnt, m_frames); end
    exp_q.delete(); got_q.delete(); got_cyc.delete();
  endtask

  task automatic test_midframe_sof();
    rdy_mode = 1;
    send_frame(100, 100);
    drain_and_clear(0);
    n_checks++;
    if (sync_err_cnt !== 8'd1) begin n_fail++; $display("FAIL sync_one: got=%0d required=1", sync_err_cnt); end
    n_checks++;
    if (got_q.size() !== CW || queue_diff() !== 0) begin
      n_fail++; $display("FAIL sync_packet: beats=%0d diffs=%0d required beats=%0d diffs=0", got_q.size(), queue_diff(), CW);
    end
    exp_q.delete(); got_q.delete(); got_cyc.delete();
    send_frame(1, 299);
    drain_and_clear(1);
    n_checks++;
    if (sync_err_cnt !== 8'd255 || m_sync != 255) begin
      n_fail++; $display("FAIL sync_saturate: got=%0d required=255", sync_err_cnt);
    end
    rdy_mode = 0;
  endtask

  task automatic test_reset_midframe();
    rdy_mode = 1;
    send_beat(1'b1, rnd_llr());
    for (int p = 1; p < 300; p++) send_beat(1'b0, rnd_llr());
    rdy_mode = 2;
    idle(6);
    n_checks++;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rst_mid_stall: out_valid=%0b required=1", out_valid); end
    reset_reset = 1'b1;
    @(posedge clk_clk); #1;
    exp_q.delete(); got_q.delete(); got_cyc.delete();
    n_pushed = 0; n_popped = 0; m_in_frame = 0; m_pos = 0; m_frames = 0; m_sync = 0;
    n_checks++;
    if ({out_valid, in_ready, frame_cnt, sync_err_cnt} !== '0) begin
      n_fail++; $display("FAIL rst_mid_state: v=%0b rdy=%0b fc=%0d se=%0d required all 0",
                         out_valid, in_ready, frame_cnt, sync_err_cnt);
    end
    reset_reset = 1'b0; rdy_mode = 0;
    @(posedge clk_clk); #1;
    send_beat(1'b0, rnd_llr());
    send_frame(1, 0);
    drain_and_clear(0);
    n_checks++;
    if (got_q.size() !== CW || queue_diff() !== 0 || got_q[0][7] !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid_clean_packet: beats=%0d diffs=%0d required beats=%0d diffs=0", got_q.size(), queue_diff(), CW);
    end
    n_checks++;
    if (frame_cnt !== 16'd1) begin n_fail++; $display("FAIL rst_mid_frame_cnt: got=%0d required=1", frame_cnt); end
    exp_q.delete(); got_q.delete(); got_cyc.delete();
  endtask

  task automatic test_throughput();
    mon_viol = 0; rdy_mode = 0;
    idle(2);
    send_frame(1, 0);
    drain_and_clear(0);
    n_checks++;
    if (got_cyc.size() !== CW || got_cyc[0] !== sof_cyc || got_cyc[CW-1] - got_cyc[0] !== CW - 1) begin
      n_fail++;
      $display("FAIL throughput_out: beats=%0d first=%0d sof=%0d span=%0d required beats=%0d first=sof span=%0d",
               got_cyc.size(), (got_cyc.size() > 0) ? got_cyc[0] : -1, sof_cyc,
               (got_cyc.size() == CW) ? got_cyc[CW-1] - got_cyc[0] : -1, CW, CW - 1);
    end
    n_checks++;
    if (last_acc_cyc - sof_cyc !== CW - 1) begin
      n_fail++; $display("FAIL throughput_in: span=%0d required=%0d", last_acc_cyc - sof_cyc, CW - 1);
    end
    n_checks++;
    if (queue_diff() !== 0 || mon_viol !== 0) begin
      n_fail++; $display("FAIL throughput_stream: diffs=%0d violations=%0d required 0/0", queue_diff(), mon_viol);
    end
    exp_q.delete(); got_q.delete(); got_cyc.delete();
  endtask

  initial begin
    test_reset();
    test_quant();
    test_framing();
    test_backpressure();
    test_midframe_sof();
    test_reset_midframe();
    test_throughput();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
